wb_arbiter: RTL and testbench

//  Writeback-side driver of the register-file write port (reg_wen/reg_waddr/reg_wdata).

---
 rtl/wb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EX results and buffered load returns onto the single
// register-file write port and tracks outstanding loads. Optional macro: WB_BYPASS_EN.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wen_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_hold_o,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_waddr_i,
    input  logic [31:0] ld_wdata_i,
    input  logic        ld_issue_i,
    input  logic [4:0]  ld_issue_addr_i,
    output logic [31:0] busy_o,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_EX   = 2'd1,
        SEL_FIFO = 2'd2,
        SEL_BYP  = 2'd3
    } sel_e;

    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_starve;
    logic [31:0]   r_busy;
    logic          r_reg_wen;
    logic [4:0]    r_reg_waddr;
    logic [31:0]   r_reg_wdata;

    logic [PW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_ex_req;
    logic          w_ld_acc;
    logic          w_ld_nz;
    logic [4:0]    w_head_addr;
    logic [31:0]   w_head_data;
    sel_e          w_sel;
    logic          w_pop;
    logic          w_push;
    logic          w_wen_nxt;
    logic [4:0]    w_waddr_nxt;
    logic [31:0]   w_wdata_nxt;
    logic [31:0]   w_clr;
    logic [31:0]   w_set;
    logic [CW-1:0] w_starve_nxt;

    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (w_count == PW'(0));
    assign w_full      = (w_count == PW'(DEPTH));
    assign w_ex_req    = ex_wen_i && (ex_waddr_i != 5'd0);
    assign w_ld_nz     = (ld_waddr_i != 5'd0);
    assign w_head_addr = r_fifo_addr[r_rptr[AW-1:0]];
    assign w_head_data = r_fifo_data[r_rptr[AW-1:0]];

    // ready depends only on the registered count, so a same-cycle pop never re-opens a full FIFO
    assign ld_ready_o  = !w_full;
    assign w_ld_acc    = ld_valid_i && ld_ready_o;
    assign ex_hold_o   = (r_starve == CW'(STARVE_LIMIT)) && ex_wen_i && !w_empty;

    assign busy_o      = r_busy;
    assign reg_wen_o   = r_reg_wen;
    assign reg_waddr_o = r_reg_waddr;
    assign reg_wdata_o = r_reg_wdata;

    // Write-port source selection
    always_comb begin
        w_sel = SEL_NONE;
        if (ex_hold_o) begin
            w_sel = SEL_FIFO;
        end else if (w_ex_req) begin
            w_sel = SEL_EX;
        end else if (!w_empty) begin
            w_sel = SEL_FIFO;
        end else begin
`ifdef WB_BYPASS_EN
            if (w_ld_acc && w_ld_nz) begin
                w_sel = SEL_BYP;
            end else begin
                w_sel = SEL_NONE;
            end
`else
            w_sel = SEL_NONE;
`endif
        end
    end

    assign w_pop  = (w_sel == SEL_FIFO);
    // loads to x0 are accepted but dropped here
    assign w_push = w_ld_acc && w_ld_nz && (w_sel != SEL_BYP);
    assign w_set  = (ld_issue_i && (ld_issue_addr_i != 5'd0)) ? (32'd1 << ld_issue_addr_i) : 32'd0;

    // Next write-port values and scoreboard clear mask
    always_comb begin
        w_wen_nxt   = 1'b0;
        w_waddr_nxt = r_reg_waddr;
        w_wdata_nxt = r_reg_wdata;
        w_clr       = 32'd0;
        case (w_sel)
            SEL_EX: begin
                w_wen_nxt   = 1'b1;
                w_waddr_nxt = ex_waddr_i;
                w_wdata_nxt = ex_wdata_i;
            end
            SEL_FIFO: begin
                w_wen_nxt   = 1'b1;
                w_waddr_nxt = w_head_addr;
                w_wdata_nxt = w_head_data;
                w_clr       = 32'd1 << w_head_addr;
            end
            SEL_BYP: begin
                w_wen_nxt   = 1'b1;
                w_waddr_nxt = ld_waddr_i;
                w_wdata_nxt = ld_wdata_i;
                w_clr       = 32'd1 << ld_waddr_i;
            end
            default: begin
                w_wen_nxt   = 1'b0;
                w_waddr_nxt = r_reg_waddr;
                w_wdata_nxt = r_reg_wdata;
                w_clr       = 32'd0;
            end
        endcase
    end

    // Starvation counter next value
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || w_empty) begin
            w_starve_nxt = CW'(0);
        end else if ((w_sel == SEL_EX) && (r_starve != CW'(STARVE_LIMIT))) begin
            w_starve_nxt = r_starve + CW'(1);
        end else begin
            w_starve_nxt = r_starve;
        end
    end

    // State registers: FIFO, counter, scoreboard, output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= PW'(0);
            r_rptr      <= PW'(0);
            r_starve    <= CW'(0);
            r_busy      <= 32'd0;
            r_reg_wen   <= 1'b0;
            r_reg_waddr <= 5'd0;
            r_reg_wdata <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i] <= 5'd0;
                r_fifo_data[i] <= 32'd0;
            end
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wptr[AW-1:0]] <= ld_waddr_i;
                r_fifo_data[r_wptr[AW-1:0]] <= ld_wdata_i;
                r_wptr <= r_wptr + PW'(1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end else begin
                r_rptr <= r_rptr;
            end
            r_starve    <= w_starve_nxt;
            // set is applied after clear so an issue wins over a same-cycle retire
            r_busy      <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
            r_reg_wen   <= w_wen_nxt;
            r_reg_waddr <= w_waddr_nxt;
            r_reg_wdata <= w_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model. Honours WB_BYPASS_EN.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wen;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_hold_o;
    logic        ld_valid;
    logic        ld_ready_o;
    logic [4:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        ld_issue;
    logic [4:0]  ld_issue_addr;
    logic [31:0] busy_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    int          m_starve;
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .ex_wen_i(ex_wen), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .ex_hold_o(ex_hold_o),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready_o),
        .ld_waddr_i(ld_waddr), .ld_wdata_i(ld_wdata),
        .ld_issue_i(ld_issue), .ld_issue_addr_i(ld_issue_addr),
        .busy_o(busy_o),
        .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic is, input logic [4:0] ia);
        ex_wen = ew; ex_waddr = ea; ex_wdata = ed;
        ld_valid = lv; ld_waddr = la; ld_wdata = ld;
        ld_issue = is; ld_issue_addr = ia;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_busy   = 32'd0;
        m_wen    = 1'b0;
        m_waddr  = 5'd0;
        m_wdata  = 32'd0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        logic exp_hold, exp_ready, acc, byp, ex_req;
        ent_t e;
        #1;
        exp_ready = (mq.size() < DEPTH);
        exp_hold  = (m_starve == LIM) && ex_wen && (mq.size() != 0);
        chk("ex_hold", 32'(ex_hold_o), 32'(exp_hold));
        chk("ld_ready", 32'(ld_ready_o), 32'(exp_ready));
        if (rst) begin
            model_reset();
        end else begin
            acc    = ld_valid && exp_ready;
            byp    = 1'b0;
            ex_req = ex_wen && (ex_waddr != 5'd0);
            if (mq.size() != 0 && (exp_hold || !ex_req)) begin
                e = mq.pop_front();
                m_wen = 1'b1; m_waddr = e.a; m_wdata = e.d;
                m_busy[e.a] = 1'b0;
                m_starve = 0;
            end else if (ex_req) begin
                m_wen = 1'b1; m_waddr = ex_waddr; m_wdata = ex_wdata;
                if (mq.size() != 0) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
                else m_starve = 0;
            end else begin
                m_wen = 1'b0;
                m_starve = 0;
`ifdef WB_BYPASS_EN
                if (acc && ld_waddr != 5'd0) begin
                    byp = 1'b1;
                    m_wen = 1'b1; m_waddr = ld_waddr; m_wdata = ld_wdata;
                    m_busy[ld_waddr] = 1'b0;
                end
`endif
            end
            if (acc && ld_waddr != 5'd0 && !byp) mq.push_back('{a: ld_waddr, d: ld_wdata});
            if (ld_issue && ld_issue_addr != 5'd0) m_busy[ld_issue_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("reg_wen", 32'(reg_wen_o), 32'(m_wen));
        chk("reg_waddr", 32'(reg_waddr_o), 32'(m_waddr));
        chk("reg_wdata", reg_wdata_o, m_wdata);
        chk("busy", busy_o, m_busy);
    endtask

    initial begin
        int k;
        logic [31:0] exd;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst reg_wen", 32'(reg_wen_o), 32'd0);
        chk("rst busy", busy_o, 32'd0);
        chk("rst ld_ready", 32'(ld_ready_o), 32'd1);
        chk("rst ex_hold", 32'(ex_hold_o), 32'd0);

        // EX only, then EX to x0
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle();
        chk("ex x5 wen", 32'(reg_wen_o), 32'd1);
        chk("ex x5 waddr", 32'(reg_waddr_o), 32'd5);
        chk("ex x5 wdata", reg_wdata_o, 32'hDEADBEEF);
        drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle();
        chk("ex x0 wen", 32'(reg_wen_o), 32'd0);

        // Load path x7
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        cycle();
        chk("issue x7 busy", 32'(busy_o[7]), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        cycle();
`ifndef WB_BYPASS_EN
        chk("ld x7 not yet", 32'(reg_wen_o), 32'd0);
        idle();
        cycle();
`endif
        chk("ld x7 wen", 32'(reg_wen_o), 32'd1);
        chk("ld x7 wdata", reg_wdata_o, 32'h1234);
        chk("ld x7 busy", 32'(busy_o[7]), 32'd0);

        // Mid-stream reset with three queued loads
        for (int i = 4; i <= 6; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i));
            cycle();
        end
        chk("busy 0x70", busy_o, 32'h0000_0070);
        for (int i = 4; i <= 6; i++) begin
            drive(1'b1, 5'd10, 32'(100 + i), 1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0);
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid rst wen", 32'(reg_wen_o), 32'd0);
        chk("mid rst busy", busy_o, 32'd0);
        chk("mid rst ready", 32'(ld_ready_o), 32'd1);
        repeat (4) cycle();

        // Full FIFO and starvation: EX writes every cycle, five loads
        for (int i = 8; i <= 12; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i));
            cycle();
        end
        k = 0;
        exd = 32'hA000_0000;
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 5'd20, exd, (k < 5), 5'(8 + k), 32'hB000_0000 + 32'(k), 1'b0, 5'd0);
            if (i == 9) begin
                #1;
                chk("starve hold", 32'(ex_hold_o), 32'd1);
            end
            if (k < 5 && mq.size() < DEPTH) k++;
            if (!((m_starve == LIM) && (mq.size() != 0))) exd++;
            cycle();
            if (i == 3) chk("full ready", 32'(ld_ready_o), 32'd0);
            if (i == 9) chk("hold pops head", 32'(reg_waddr_o), 32'd8);
            if (i == 10) chk("ex after hold", 32'(reg_waddr_o), 32'd20);
        end
        idle();
        repeat (6) cycle();
        chk("drained busy", busy_o, 32'd0);

        // Same-cycle set and clear of busy[3]
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle();
        drive(1'b1, 5'd21, 32'h55, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle();
        chk("x3 pop wdata", reg_wdata_o, 32'h33);
        chk("x3 set wins", 32'(busy_o[3]), 32'd1);
        idle();
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
